// File: rtl/id_stage_if.sv
// Signal bundle between IF/ID, WB, the hazard unit and the ID/EX register
// for the decode stage. The stage itself uses the slave modport; whatever
// feeds it (pipeline registers or a testbench) uses the master modport.
interface id_stage_if;
  // Inputs to the decode stage
  logic [31:0] pc_in;
  logic [31:0] instruction;
  logic [3:0]  status_reg;
  logic        hazard;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  // Outputs towards ID/EX and the hazard unit
  logic [31:0] pc;
  logic        wb_en;
  logic        mem_read;
  logic        mem_write;
  logic        b;
  logic        status;
  logic [3:0]  alu_command;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic [11:0] shift_operand;
  logic        imm;
  logic [23:0] signed_imm;
  logic [3:0]  dest;
  logic [3:0]  status_reg_data;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;

  modport master (
    output pc_in, instruction, status_reg, hazard, wb_wb_en, wb_dest, wb_value,
    input  pc, wb_en, mem_read, mem_write, b, status, alu_command, val_rn,
           val_rm, shift_operand, imm, signed_imm, dest, status_reg_data,
           src1, src2, two_src
  );

  modport slave (
    input  pc_in, instruction, status_reg, hazard, wb_wb_en, wb_dest, wb_value,
    output pc, wb_en, mem_read, mem_write, b, status, alu_command, val_rn,
           val_rm, shift_operand, imm, signed_imm, dest, status_reg_data,
           src1, src2, two_src
  );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage: register file R0-R14 with write-back bypass,
// control decode, condition evaluation against NZCV and hazard bubbling.
// Everything except the register file itself is combinational; ID/EX
// samples the outputs on the next rising edge.
module id_stage (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  // Condition field evaluation; flags are {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      4'b1111: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [31:0] regs_r [0:14];

  logic [3:0]  alu_s;
  logic        wb_raw_s;
  logic        mem_read_raw_s;
  logic        mem_write_raw_s;
  logic        b_raw_s;
  logic        status_raw_s;
  logic        pass_s;
  logic [3:0]  src1_s;
  logic [3:0]  src2_s;
  logic [31:0] val_rn_s;
  logic [31:0] val_rm_s;

  // Register file: async clear while rst is low, R15 writes are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 15; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (bus.wb_wb_en && (bus.wb_dest != 4'd15)) begin
      regs_r[bus.wb_dest] <= bus.wb_value;
    end
  end

  // Control decode by instruction class, before condition/hazard gating.
  always_comb begin
    alu_s           = 4'b0000;
    wb_raw_s        = 1'b0;
    mem_read_raw_s  = 1'b0;
    mem_write_raw_s = 1'b0;
    b_raw_s         = 1'b0;
    status_raw_s    = 1'b0;
    case (bus.instruction[27:26])
      2'b00: begin
        status_raw_s = bus.instruction[20];
        case (bus.instruction[24:21])
          4'b1101: begin alu_s = 4'b0001; wb_raw_s = 1'b1; end
          4'b1111: begin alu_s = 4'b1001; wb_raw_s = 1'b1; end
          4'b0100: begin alu_s = 4'b0010; wb_raw_s = 1'b1; end
          4'b0101: begin alu_s = 4'b0011; wb_raw_s = 1'b1; end
          4'b0010: begin alu_s = 4'b0100; wb_raw_s = 1'b1; end
          4'b0110: begin alu_s = 4'b0101; wb_raw_s = 1'b1; end
          4'b0000: begin alu_s = 4'b0110; wb_raw_s = 1'b1; end
          4'b1100: begin alu_s = 4'b0111; wb_raw_s = 1'b1; end
          4'b0001: begin alu_s = 4'b1000; wb_raw_s = 1'b1; end
          4'b1010: begin alu_s = 4'b0100; wb_raw_s = 1'b0; end
          4'b1000: begin alu_s = 4'b0110; wb_raw_s = 1'b0; end
          default: begin alu_s = 4'b0000; wb_raw_s = 1'b0; end
        endcase
      end
      2'b01: begin
        alu_s = 4'b0010;
        if (bus.instruction[20]) begin
          mem_read_raw_s = 1'b1;
          wb_raw_s       = 1'b1;
        end else begin
          mem_write_raw_s = 1'b1;
        end
      end
      2'b10: begin
        b_raw_s = 1'b1;
      end
      default: begin
        alu_s = 4'b0000;
      end
    endcase
  end

  // Source indices; STR reads its store data from the Rd field.
  always_comb begin
    src1_s = bus.instruction[19:16];
    if (mem_write_raw_s) begin
      src2_s = bus.instruction[15:12];
    end else begin
      src2_s = bus.instruction[3:0];
    end
  end

  // Read port Rn: R15 is the PC, otherwise a same-cycle write-back wins.
  always_comb begin
    if (src1_s == 4'd15) begin
      val_rn_s = bus.pc_in;
    end else if (rst && bus.wb_wb_en && (bus.wb_dest == src1_s)) begin
      val_rn_s = bus.wb_value;
    end else begin
      val_rn_s = regs_r[src1_s];
    end
  end

  // Read port Rm: same rules as Rn.
  always_comb begin
    if (src2_s == 4'd15) begin
      val_rm_s = bus.pc_in;
    end else if (rst && bus.wb_wb_en && (bus.wb_dest == src2_s)) begin
      val_rm_s = bus.wb_value;
    end else begin
      val_rm_s = regs_r[src2_s];
    end
  end

  // A failed condition and a hazard stall collapse into the same bubble.
  always_comb begin
    pass_s = cond_pass(bus.instruction[31:28], bus.status_reg) & ~bus.hazard;
  end

  assign bus.wb_en           = wb_raw_s & pass_s;
  assign bus.mem_read        = mem_read_raw_s & pass_s;
  assign bus.mem_write       = mem_write_raw_s & pass_s;
  assign bus.b               = b_raw_s & pass_s;
  assign bus.status          = status_raw_s & pass_s;
  assign bus.alu_command     = alu_s;
  assign bus.pc              = bus.pc_in;
  assign bus.val_rn          = val_rn_s;
  assign bus.val_rm          = val_rm_s;
  assign bus.shift_operand   = bus.instruction[11:0];
  assign bus.imm             = bus.instruction[25];
  assign bus.signed_imm      = bus.instruction[23:0];
  assign bus.dest            = bus.instruction[15:12];
  assign bus.status_reg_data = bus.status_reg;
  assign bus.src1            = src1_s;
  assign bus.src2            = src2_s;
  assign bus.two_src         = ~bus.instruction[25] | mem_write_raw_s;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage ARM pipeline. It sits between the IF/ID register and the ID/EX register, and feeds every input of the ID/EX register directly. It holds the architectural register file (R0–R14), decodes the fetched word into control signals, evaluates the condition field against the current NZCV flags, and reports source registers to the hazard unit. Write-back from the WB stage lands here.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- pc_in  in  32  PC of the instruction, from IF/ID.
- instruction  in  32  fetched instruction word, from IF/ID.
- status_reg  in  4  current flags {N,Z,C,V}; N is bit 3.
- hazard  in  1  stall request from the hazard unit; inserts a bubble.
- wb_wb_en  in  1  write-back enable from WB.
- wb_dest  in  4  write-back register index.
- wb_value  in  32  write-back data.
- pc  out  32  equals pc_in.
- wb_en, mem_read, mem_write, b, status  out  1 each  control signals to ID/EX.
- alu_command  out  4  EX operation code.
- val_rn, val_rm  out  32  operand values.
- shift_operand  out  12  instruction[11:0].
- imm  out  1  instruction[25].
- signed_imm  out  24  instruction[23:0].
- dest  out  4  instruction[15:12].
- status_reg_data  out  4  equals status_reg; EX uses it for the carry-in of ADC/SBC.
- src1, src2  out  4  source indices for the hazard unit.
- two_src  out  1  src2 is a real operand.

## Operation
- **Register file.** 15 × 32 bit, indices 0–14.
  - All entries reset to 0 asynchronously while rst is low.
  - Write on a rising clk edge when rst is high, wb_wb_en=1 and wb_dest≠15.
  - Writes to index 15 are ignored.
- **Reads.** Both read ports are combinational.
  - A read of index 15 returns pc_in.
  - Write bypass: if wb_wb_en=1, rst is high and the read index equals wb_dest (and is not 15), the port returns wb_value in the same cycle.
- **Source selection.**
  - src1 = instruction[19:16]; val_rn reads src1.
  - src2 = instruction[15:12] when the instruction is STR, otherwise instruction[3:0]; val_rm reads src2.
  - two_src = ~instruction[25] | mem_write_raw.
- **Decode by mode = instruction[27:26]:**
  - **00, data processing.** Opcode is instruction[24:21]; S is instruction[20].

    | Opcode | Instruction | alu_command | wb_en |
    |---|---|---|---|
    | 1101 | MOV | 0001 | 1 |
    | 1111 | MVN | 1001 | 1 |
    | 0100 | ADD | 0010 | 1 |
    | 0101 | ADC | 0011 | 1 |
    | 0010 | SUB | 0100 | 1 |
    | 0110 | SBC | 0101 | 1 |
    | 0000 | AND | 0110 | 1 |
    | 1100 | ORR | 0111 | 1 |
    | 0001 | EOR | 1000 | 1 |
    | 1010 | CMP | 0100 | 0 |
    | 1000 | TST | 0110 | 0 |

    - Any other opcode: alu_command=0000, wb_en=0.
    - status = S.
  - **01, memory.** alu_command=0010, status=0.
    - instruction[20]=1 (LDR): mem_read=1, wb_en=1.
    - instruction[20]=0 (STR): mem_write=1.
  - **10, branch.** b=1, alu_command=0000, status=0.
  - **11.** All control signals 0, alu_command=0000.
- **Condition check.** cond = instruction[31:28].
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V.
  - 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V.
  - 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 true; 1111 false.
- **Bubble.** If the condition fails or hazard=1, wb_en, mem_read, mem_write, b and status are forced to 0. alu_command and the data outputs pass through unchanged.

## Timing
- Decode, condition check, register read and bypass are purely combinational. There is no latency within the stage; ID/EX captures the outputs at the next rising edge.
- A write-back becomes architecturally visible at the rising edge. In the same cycle it is already visible through the bypass, so no extra stall is needed for the WB→ID distance.
- Reset behaviour:
  - While rst is low, all registers read 0 and the bypass is disabled.
  - Control and decode outputs still follow instruction combinationally. ID/EX is responsible for flushing them during reset.
- Reset asserted mid-write: the register file clears immediately. The write at the next edge is discarded if rst is still low at that edge.
- Simultaneous events:
  - A write to the same index that both ports read: both ports return wb_value.
  - hazard=1 together with a failing condition: a single bubble.

## Test plan
1. **Reset.** Hold rst=0, then release; read R0–R14 via src1 → val_rn=0 for every index. Read src1=15 with pc_in=0x40 → val_rn=0x40.
2. **Write and bypass.** wb_wb_en=1, wb_dest=3, wb_value=0xDEADBEEF, instruction ADD R1,R3,R3 (0xE0831003) → val_rn=val_rm=0xDEADBEEF in the same cycle. After the edge, with wb_wb_en=0 → still 0xDEADBEEF.
3. **R15 write.** wb_dest=15 with wb_value=5 → no register changes; a read of 15 still returns pc_in.
4. **Decode sweep.**
   - MOV R0,#20 (0xE3A00014) → alu_command=0001, wb_en=1, imm=1, two_src=0.
   - STR R2,[R1] (0xE5812000) → mem_write=1, src2=2, two_src=1.
   - LDR (0xE5910000) → mem_read=1, wb_en=1.
   - B (0xEAFFFFFE) → b=1, signed_imm=0xFFFFFE.
5. **Condition.**
   - status_reg=0100 (Z=1): EQ ADD (0x00812003) → wb_en=1; NE ADD (0x10812003) → all control signals 0.
   - status_reg=1001 (N=1, V=1): GE → pass; LT → bubble.
6. **Hazard.** AL SUBS (0xE0512003) with hazard=1 → wb_en=0, status=0, alu_command=0100; val_rn and val_rm unchanged.
